// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bus between the instruction-fetch stage and its neighbours.
//   stall         - hazard controller request to hold PC and IF/ID
//   branch_taken  - execute-stage redirect request
//   branch_target - redirect address, valid with branch_taken
//   imem_addr     - instruction-memory address (the PC register)
//   imem_data     - same-cycle read data for imem_addr
//   instruc       - IF/ID instruction register
//   pc_plus1      - IF/ID copy of fetched PC+1
//   if_valid      - IF/ID holds a real instruction
//   halted        - fetch is in the HALT state
//   stall_count   - saturating count of stalled cycles in RUN
// Modports: master = fetch stage side, slave = surrounding pipeline/memory.
interface fetch_stage_if #(
   parameter int unsigned PC_WIDTH = 16
);
   logic                stall;
   logic                branch_taken;
   logic [PC_WIDTH-1:0] branch_target;
   logic [PC_WIDTH-1:0] imem_addr;
   logic [15:0]         imem_data;
   logic [15:0]         instruc;
   logic [PC_WIDTH-1:0] pc_plus1;
   logic                if_valid;
   logic                halted;
   logic [15:0]         stall_count;

   modport master (
      input  stall, branch_taken, branch_target, imem_data,
      output imem_addr, instruc, pc_plus1, if_valid, halted, stall_count
   );

   modport slave (
      output stall, branch_taken, branch_target, imem_data,
      input  imem_addr, instruc, pc_plus1, if_valid, halted, stall_count
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 16-bit pipelined core.
// Owns the PC, drives the instruction-memory address and holds the IF/ID
// register. Supports stall, branch flush, a HALT state entered on fetching
// HALT_WORD, and a saturating debug counter of stalled cycles.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - fetch_stage_if.master (stall/branch inputs, imem bus, IF/ID outputs)
module fetch_stage #(
   parameter int unsigned         PC_WIDTH  = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
   parameter logic [15:0]         NOP_WORD  = 16'h0000,
   parameter logic [15:0]         HALT_WORD = 16'hFFFF
) (
   input logic           clock,
   input logic           reset,
   fetch_stage_if.master bus
);

   localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t              state, state_nx;
   logic [PC_WIDTH-1:0] pc, pc_nx, pc_inc;
   logic [PC_WIDTH-1:0] pp1, pp1_nx;
   logic [15:0]         instr, instr_nx;
   logic                valid, valid_nx;
   logic [15:0]         cnt, cnt_nx;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      pp1_nx   = pp1;
      instr_nx = instr;
      valid_nx = valid;
      cnt_nx   = cnt;
      pc_inc   = pc + PC_ONE;
      unique case (state)
         RUN: begin
            if (bus.branch_taken) begin
               // Flush wins over stall; stalled cycle is not counted.
               pc_nx    = bus.branch_target;
               instr_nx = NOP_WORD;
               valid_nx = 1'b0;
               pp1_nx   = '0;
            end else if (bus.stall) begin
               if (cnt != '1) begin
                  cnt_nx = cnt + 16'd1;
               end
            end else begin
               pc_nx    = pc_inc;
               pp1_nx   = pc_inc;
               instr_nx = bus.imem_data;
               valid_nx = 1'b1;
               // The halt word itself is latched so decode sees it once.
               if (bus.imem_data == HALT_WORD) begin
                  state_nx = HALT;
               end
            end
         end
         HALT: begin
            instr_nx = NOP_WORD;
            valid_nx = 1'b0;
         end
         default: begin
            state_nx = RUN;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc    <= RESET_PC;
         pp1   <= '0;
         instr <= NOP_WORD;
         valid <= 1'b0;
         cnt   <= '0;
      end else begin
         pc    <= pc_nx;
         pp1   <= pp1_nx;
         instr <= instr_nx;
         valid <= valid_nx;
         cnt   <= cnt_nx;
      end
   end

   assign bus.imem_addr   = pc;
   assign bus.instruc     = instr;
   assign bus.pc_plus1    = pp1;
   assign bus.if_valid    = valid;
   assign bus.halted      = (state == HALT);
   assign bus.stall_count = cnt;

endmodule
